window_motor_drive: RTL and testbench
=====================================

Name: window_motor_drive

Overview:
- Power-stage end of the INM motor-command interface: consumes the 2-bit INM command from the anti-pinch controller and drives the window-lift H-bridge.
- Adds dead-time on every energise and reversal, a soft-start PWM ramp, brake control, and a travel-position counter with end-stop cut-off.
- The position counter emulates the window travel time: 5000 cycles at the 1 kHz SYSCLK, i.e. 5 s.
- Reports end-of-travel status back to the controller side.

Parameters:
- TRAVEL, 5000: full-travel length in SYSCLK cycles, counted from bottom (0) to top.
- POS_W, 13: position counter width; must satisfy 2^POS_W > TRAVEL.
- DEADTIME, 3: cycles with both drives low before any drive is energised.
- PWM_PERIOD, 4: PWM frame length in cycles.
- RAMP_STEP, 8: cycles per duty increment during soft start.
- POS_INIT, 0: position loaded at reset (window fully open).

Ports:
- SYSCLK  in  1  system clock, 1 kHz
- RST_N  in  1  asynchronous active-low reset
- INM  in  2  motor command: 00 off, 01 up/close, 10 down/open, 11 brake
- DRV_UP  out  1  H-bridge up-side enable, PWM'd
- DRV_DN  out  1  H-bridge down-side enable, PWM'd
- BRAKE_EN  out  1  low-side short (brake)
- POS  out  POS_W  current position, 0..TRAVEL
- AT_TOP  out  1  POS == TRAVEL
- AT_BOTTOM  out  1  POS == 0
- LIMIT_HIT  out  1  one-cycle pulse when an end-stop cuts the drive

Behaviour:
- Clock and reset:
  - Single clock domain; reset is asynchronous and active-low (RST_N); all outputs are registered.
  - Reset values: DRV_UP=0, DRV_DN=0, BRAKE_EN=0, LIMIT_HIT=0, POS=POS_INIT, state=IDLE; AT_TOP and AT_BOTTOM are decoded from POS (AT_BOTTOM=1 for the default POS_INIT).
  - Reset mid-run forces outputs low immediately and reloads POS=POS_INIT.
- States: IDLE, DEAD, RUN_UP, RUN_DN, BRAKE.
  - IDLE: all drives low. INM=01 with !AT_TOP -> DEAD(dir=up). INM=10 with !AT_BOTTOM -> DEAD(dir=dn). INM=11 -> BRAKE.
  - DEAD: drives low, dead counter counts DEADTIME cycles, then -> RUN_<dir>. If INM changes during DEAD, re-evaluate from IDLE rules on that edge; the dead counter restarts if the direction changed.
  - RUN_UP / RUN_DN:
    - INM=00 -> IDLE; INM=11 -> BRAKE (drive low and BRAKE_EN=1 on the same edge).
    - INM = opposite direction -> DEAD(new dir).
    - End-stop -> IDLE.
  - BRAKE: BRAKE_EN=1 while INM=11. INM=00 -> IDLE; INM=01/10 -> DEAD (same end-stop guards as IDLE).
- Latency: INM=01 first sampled at edge k in IDLE gives DRV_UP first high after edge k+DEADTIME. Stop (INM=00) drops the drive after the next edge.
- Soft start:
  - On RUN entry, duty=1 and the PWM counter is 0.
  - Duty increments by 1 every RAMP_STEP RUN cycles, saturating at PWM_PERIOD (100%).
  - DRV_x = (pwm_cnt < duty). With defaults, full duty is reached 24 cycles after RUN entry.
  - Ramp restarts on every RUN entry.
- Position:
  - POS +1 on every RUN_UP cycle and -1 on every RUN_DN cycle, independent of the PWM phase.
  - On the edge where POS becomes TRAVEL (or 0): state -> IDLE, drive low, LIMIT_HIT=1 for one cycle.
  - POS never leaves 0..TRAVEL.
  - Commands toward an already-reached end-stop are ignored (stay IDLE, no LIMIT_HIT).
- Invariants:
  - DRV_UP & DRV_DN never both 1.
  - BRAKE_EN is never 1 together with either drive.
  - Every drive transition from low passes through at least DEADTIME cycles of DEAD.

Decomposition:
- Shared package anti_pinch_pkg:
  - INM encoding constants (INM_OFF, INM_UP, INM_DN, INM_BRK).
  - Drive state enum/encoding.
  - Default TRAVEL.
- Sub-module pwm_ramp:
  - Inputs: SYSCLK, RST_N, start (RUN entry), run.
  - Output: pwm_out.
  - Holds the duty ramp and PWM counter.
  - Instantiated once; its output is steered to DRV_UP or DRV_DN by the top FSM.

Test Plan:
- Reset then INM=01 at edge k -> DRV_UP low through k+2, first high after k+3. Duty pattern 1/4, 2/4, 3/4, then 4/4 from cycle 24 after RUN entry. DRV_DN=0 throughout.
- INM=01 held 6000 cycles -> POS reaches 5000; DRV_UP drops on that edge; LIMIT_HIT pulses once; AT_TOP=1. A further INM=01 produces no drive.
- Running up at POS=100, INM switches to 10 -> both drives low for 3 cycles, then DRV_DN ramps from 1/4. POS counts down from the reversal value with no gap.
- Running down, INM=11 -> next edge DRV_DN=0, BRAKE_EN=1. INM=00 -> BRAKE_EN=0. INM=10 -> DEAD of 3 cycles precedes DRV_DN.
- At reset POS=0, INM=10 -> stays IDLE, all drives 0, no LIMIT_HIT.
- RST_N pulsed low mid-RUN_UP at POS=2500 -> outputs 0 immediately, POS=0, state IDLE after release. Check the no-overlap invariants on every cycle of every test.

Source files
------------

// File: rtl/anti_pinch_pkg.sv
// Shared definitions for the window-lift drive path: INM command encoding,
// drive-state encoding and the default travel length.
package anti_pinch_pkg;

  localparam logic [1:0] INM_OFF = 2'b00;
  localparam logic [1:0] INM_UP  = 2'b01;
  localparam logic [1:0] INM_DN  = 2'b10;
  localparam logic [1:0] INM_BRK = 2'b11;

  // Full travel in SYSCLK cycles (5 s at 1 kHz)
  localparam int TRAVEL_DEFAULT = 5000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAD   = 3'd1,
    ST_RUN_UP = 3'd2,
    ST_RUN_DN = 3'd3,
    ST_BRAKE  = 3'd4
  } drive_state_e;

  function automatic logic is_run(drive_state_e s);
    return (s == ST_RUN_UP) || (s == ST_RUN_DN);
  endfunction

endpackage

// File: rtl/pwm_ramp.sv
// Soft-start PWM generator. The inputs describe the coming cycle (start = first
// RUN cycle, run = any RUN cycle), and pwm_out is the level for that coming
// cycle, so the caller can register it straight into the drive flops.
module pwm_ramp #(
  parameter int PWM_PERIOD = 4,
  parameter int RAMP_STEP  = 8
) (
  input  logic SYSCLK,
  input  logic RST_N,
  input  logic start,
  input  logic run,
  output logic pwm_out
);

  localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
  localparam int STEP_W = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_MIN  = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_PERIOD);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP - 1);

  logic [CNT_W-1:0]  r_cnt,  w_cnt_nxt;
  logic [DUTY_W-1:0] r_duty, w_duty_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;

  // Next PWM phase, duty and ramp-step count; ramp restarts on start
  always_comb begin
    w_cnt_nxt  = '0;
    w_duty_nxt = DUTY_MIN;
    w_step_nxt = '0;
    if (start) begin
      w_cnt_nxt  = '0;
      w_duty_nxt = DUTY_MIN;
      w_step_nxt = '0;
    end else if (run) begin
      w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      if (r_step == STEP_LAST) begin
        w_step_nxt = '0;
        w_duty_nxt = (r_duty == DUTY_FULL) ? DUTY_FULL : r_duty + 1'b1;
      end else begin
        w_step_nxt = r_step + 1'b1;
        w_duty_nxt = r_duty;
      end
    end
  end

  assign pwm_out = (start | run) && (DUTY_W'(w_cnt_nxt) < w_duty_nxt);

  // Ramp state registers
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt  <= '0;
      r_duty <= DUTY_MIN;
      r_step <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_duty <= w_duty_nxt;
      r_step <= w_step_nxt;
    end
  end

endmodule

// File: rtl/window_motor_drive.sv
// H-bridge drive for the window lift: dead-time on every energise/reversal,
// soft-start PWM, brake, and a travel-position counter with end-stop cut-off.
//
//   state   | meaning
//   IDLE    | all drives off, waiting for a command
//   DEAD    | both drives low for DEADTIME cycles before energising
//   RUN_UP  | up-side PWM'd, position counting up
//   RUN_DN  | down-side PWM'd, position counting down
//   BRAKE   | low-side short while INM=11
module window_motor_drive
  import anti_pinch_pkg::*;
#(
  parameter int TRAVEL     = TRAVEL_DEFAULT,
  parameter int POS_W      = 13,
  parameter int DEADTIME   = 3,
  parameter int PWM_PERIOD = 4,
  parameter int RAMP_STEP  = 8,
  parameter int POS_INIT   = 0
) (
  input  logic             SYSCLK,
  input  logic             RST_N,
  input  logic [1:0]       INM,
  output logic             DRV_UP,
  output logic             DRV_DN,
  output logic             BRAKE_EN,
  output logic [POS_W-1:0] POS,
  output logic             AT_TOP,
  output logic             AT_BOTTOM,
  output logic             LIMIT_HIT
);

  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [POS_W-1:0] P_TOP   = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] P_TOP_1 = POS_W'(TRAVEL - 1);
  localparam logic [POS_W-1:0] P_BOT   = '0;
  localparam logic [POS_W-1:0] P_BOT_1 = POS_W'(1);
  localparam logic [POS_W-1:0] P_INIT  = POS_W'(POS_INIT);
  localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEADTIME - 1);

  drive_state_e     r_state, w_state_nxt, w_idle_state;
  logic             r_dir_up, w_dir_up_nxt, w_idle_dir_up;
  logic [DT_W-1:0]  r_dead_cnt, w_dead_cnt_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  logic             w_limit, w_can_up, w_can_dn;
  logic             w_ramp_start, w_ramp_run, w_pwm;
  logic             r_drv_up, r_drv_dn, r_brake_en;
  logic             r_at_top, r_at_bottom, r_limit_hit;

  assign w_can_up = (r_pos != P_TOP);
  assign w_can_dn = (r_pos != P_BOT);

  // Command decode shared by IDLE, BRAKE and a changed command during DEAD
  always_comb begin
    w_idle_state  = ST_IDLE;
    w_idle_dir_up = r_dir_up;
    case (INM)
      INM_UP: if (w_can_up) begin
        w_idle_state  = ST_DEAD;
        w_idle_dir_up = 1'b1;
      end
      INM_DN: if (w_can_dn) begin
        w_idle_state  = ST_DEAD;
        w_idle_dir_up = 1'b0;
      end
      INM_BRK: w_idle_state = ST_BRAKE;
      default: w_idle_state = ST_IDLE;
    endcase
  end

  // Next state, direction and position; end-stop overrides the command
  always_comb begin
    w_state_nxt  = r_state;
    w_dir_up_nxt = r_dir_up;
    w_pos_nxt    = r_pos;
    w_limit      = 1'b0;
    case (r_state)
      ST_IDLE, ST_BRAKE: begin
        w_state_nxt  = w_idle_state;
        w_dir_up_nxt = w_idle_dir_up;
      end
      ST_DEAD: begin
        if (INM == (r_dir_up ? INM_UP : INM_DN)) begin
          if (r_dead_cnt == '0) w_state_nxt = r_dir_up ? ST_RUN_UP : ST_RUN_DN;
        end else begin
          w_state_nxt  = w_idle_state;
          w_dir_up_nxt = w_idle_dir_up;
        end
      end
      ST_RUN_UP: begin
        if (w_can_up) w_pos_nxt = r_pos + 1'b1;
        if (r_pos == P_TOP_1 || !w_can_up) begin
          w_state_nxt = ST_IDLE;
          w_limit     = 1'b1;
        end else begin
          case (INM)
            INM_OFF: w_state_nxt = ST_IDLE;
            INM_BRK: w_state_nxt = ST_BRAKE;
            INM_DN: begin
              w_state_nxt  = ST_DEAD;
              w_dir_up_nxt = 1'b0;
            end
            default: w_state_nxt = ST_RUN_UP;
          endcase
        end
      end
      ST_RUN_DN: begin
        if (w_can_dn) w_pos_nxt = r_pos - 1'b1;
        if (r_pos == P_BOT_1 || !w_can_dn) begin
          w_state_nxt = ST_IDLE;
          w_limit     = 1'b1;
        end else begin
          case (INM)
            INM_OFF: w_state_nxt = ST_IDLE;
            INM_BRK: w_state_nxt = ST_BRAKE;
            INM_UP: begin
              w_state_nxt  = ST_DEAD;
              w_dir_up_nxt = 1'b1;
            end
            default: w_state_nxt = ST_RUN_DN;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dead-time counter reloads on DEAD entry or a direction change inside DEAD
  always_comb begin
    w_dead_cnt_nxt = r_dead_cnt;
    if (w_state_nxt == ST_DEAD) begin
      if (r_state != ST_DEAD || w_dir_up_nxt != r_dir_up) w_dead_cnt_nxt = DT_LOAD;
      else if (r_dead_cnt != '0) w_dead_cnt_nxt = r_dead_cnt - 1'b1;
    end
  end

  assign w_ramp_run   = is_run(w_state_nxt);
  assign w_ramp_start = w_ramp_run && !is_run(r_state);

  pwm_ramp #(
    .PWM_PERIOD (PWM_PERIOD),
    .RAMP_STEP  (RAMP_STEP)
  ) u_pwm_ramp (
    .SYSCLK  (SYSCLK),
    .RST_N   (RST_N),
    .start   (w_ramp_start),
    .run     (w_ramp_run),
    .pwm_out (w_pwm)
  );

  // FSM state, direction, dead counter and position registers
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_dir_up   <= 1'b1;
      r_dead_cnt <= '0;
      r_pos      <= P_INIT;
    end else begin
      r_state    <= w_state_nxt;
      r_dir_up   <= w_dir_up_nxt;
      r_dead_cnt <= w_dead_cnt_nxt;
      r_pos      <= w_pos_nxt;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_drv_up    <= 1'b0;
      r_drv_dn    <= 1'b0;
      r_brake_en  <= 1'b0;
      r_at_top    <= (P_INIT == P_TOP);
      r_at_bottom <= (P_INIT == P_BOT);
      r_limit_hit <= 1'b0;
    end else begin
      r_drv_up    <= (w_state_nxt == ST_RUN_UP) && w_pwm;
      r_drv_dn    <= (w_state_nxt == ST_RUN_DN) && w_pwm;
      r_brake_en  <= (w_state_nxt == ST_BRAKE);
      r_at_top    <= (w_pos_nxt == P_TOP);
      r_at_bottom <= (w_pos_nxt == P_BOT);
      r_limit_hit <= w_limit;
    end
  end

  assign DRV_UP    = r_drv_up;
  assign DRV_DN    = r_drv_dn;
  assign BRAKE_EN  = r_brake_en;
  assign POS       = r_pos;
  assign AT_TOP    = r_at_top;
  assign AT_BOTTOM = r_at_bottom;
  assign LIMIT_HIT = r_limit_hit;

endmodule

// File: tb/tb_window_motor_drive.sv
// Bench for window_motor_drive: directed scenarios plus random command bursts,
// every cycle compared against a behavioural model of the window drive.
module tb_window_motor_drive;

  localparam int TRAVEL   = 5000;
  localparam int DEADTIME = 3;
  localparam int PER      = 4;
  localparam int RAMP     = 8;

  logic        SYSCLK = 1'b0;
  logic        RST_N  = 1'b1;
  logic [1:0]  INM    = 2'b00;
  logic        DRV_UP, DRV_DN, BRAKE_EN, AT_TOP, AT_BOTTOM, LIMIT_HIT;
  logic [12:0] POS;

  int n_checks = 0;
  int n_fail   = 0;
  int lim_seen = 0;

  window_motor_drive dut (
    .SYSCLK    (SYSCLK),
    .RST_N     (RST_N),
    .INM       (INM),
    .DRV_UP    (DRV_UP),
    .DRV_DN    (DRV_DN),
    .BRAKE_EN  (BRAKE_EN),
    .POS       (POS),
    .AT_TOP    (AT_TOP),
    .AT_BOTTOM (AT_BOTTOM),
    .LIMIT_HIT (LIMIT_HIT)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 stopped, 1 waiting out dead-time, 2 driving, 3 braking
  int m_mode, m_dir, m_wait, m_age, m_pos, m_limit;

  function automatic int cmd_for(input int dir);
    return (dir > 0) ? 1 : 2;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_dir = 1; m_wait = 0; m_age = 0; m_pos = 0; m_limit = 0;
  endtask

  task automatic m_command(input int cmd);
    if (cmd == 1 && m_pos < TRAVEL) begin
      m_mode = 1; m_dir = 1; m_wait = 0;
    end else if (cmd == 2 && m_pos > 0) begin
      m_mode = 1; m_dir = -1; m_wait = 0;
    end else if (cmd == 3) begin
      m_mode = 3;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic m_step(input int cmd);
    m_limit = 0;
    case (m_mode)
      2: begin
        m_pos += m_dir;
        if ((m_dir > 0 && m_pos == TRAVEL) || (m_dir < 0 && m_pos == 0)) begin
          m_mode = 0; m_limit = 1;
        end else if (cmd == cmd_for(m_dir)) begin
          m_age++;
        end else if (cmd == cmd_for(-m_dir)) begin
          m_mode = 1; m_dir = -m_dir; m_wait = 0;
        end else if (cmd == 3) begin
          m_mode = 3;
        end else begin
          m_mode = 0;
        end
      end
      1: begin
        if (cmd == cmd_for(m_dir)) begin
          m_wait++;
          if (m_wait == DEADTIME) begin
            m_mode = 2; m_age = 0;
          end
        end else begin
          m_command(cmd);
        end
      end
      default: m_command(cmd);
    endcase
  endtask

  function automatic int exp_drive(input int dir);
    if (m_mode != 2 || m_dir != dir) return 0;
    return ((m_age % PER) < min2(PER, 1 + m_age / RAMP)) ? 1 : 0;
  endfunction

  task automatic check_outputs();
    check_val("drv_up",    32'(DRV_UP),    32'(exp_drive(1)));
    check_val("drv_dn",    32'(DRV_DN),    32'(exp_drive(-1)));
    check_val("brake_en",  32'(BRAKE_EN),  32'(m_mode == 3));
    check_val("pos",       32'(POS),       32'(m_pos));
    check_val("at_top",    32'(AT_TOP),    32'(m_pos == TRAVEL));
    check_val("at_bottom", 32'(AT_BOTTOM), 32'(m_pos == 0));
    check_val("limit_hit", 32'(LIMIT_HIT), 32'(m_limit));
    check_val("up_dn_overlap", 32'(DRV_UP & DRV_DN), 32'(0));
    check_val("brake_drive_overlap", 32'(BRAKE_EN & (DRV_UP | DRV_DN)), 32'(0));
  endtask

  // One clock: apply command (called at a falling edge), step model, check, return at next falling edge
  task automatic cyc(input int cmd);
    INM = 2'(cmd);
    @(posedge SYSCLK);
    m_step(cmd);
    #1;
    lim_seen += int'(LIMIT_HIT);
    check_outputs();
    @(negedge SYSCLK);
  endtask

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    INM   = 2'b00;
    #1;
    m_reset();
    check_val({tag, "_drv_up"},   32'(DRV_UP),    32'(0));
    check_val({tag, "_drv_dn"},   32'(DRV_DN),    32'(0));
    check_val({tag, "_brake"},    32'(BRAKE_EN),  32'(0));
    check_val({tag, "_pos"},      32'(POS),       32'(0));
    check_val({tag, "_at_bot"},   32'(AT_BOTTOM), 32'(1));
    check_val({tag, "_limit"},    32'(LIMIT_HIT), 32'(0));
    @(negedge SYSCLK);
    @(negedge SYSCLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hi;
    int drv_seen;
    int hold;
    int cmd;
    int done;

    m_reset();
    #2;
    @(negedge SYSCLK);
    do_reset("rst0");
    check_outputs();

    // Latency and soft-start ramp
    first_hi = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (first_hi < 0 && DRV_UP) first_hi = i;
    end
    check_val("first_high_edge", 32'(first_hi), 32'(DEADTIME));

    // Full travel to the top end-stop
    lim_seen = 0;
    for (int i = 0; i < 6000; i++) cyc(1);
    check_val("limit_pulses_top", 32'(lim_seen), 32'(1));
    check_val("at_top_after_travel", 32'(AT_TOP), 32'(1));
    drv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      drv_seen += int'(DRV_UP | DRV_DN);
    end
    check_val("no_drive_at_top", 32'(drv_seen), 32'(0));
    check_val("limit_pulses_after", 32'(lim_seen), 32'(1));

    // Reversal at position 100, then brake / release / resume down
    do_reset("rst1");
    for (int i = 0; i < 200 && m_pos < 100; i++) cyc(1);
    for (int i = 0; i < 40; i++) cyc(2);
    for (int i = 0; i < 5; i++) cyc(3);
    for (int i = 0; i < 3; i++) cyc(0);
    for (int i = 0; i < 12; i++) cyc(2);

    // Down command at the bottom is ignored
    do_reset("rst2");
    lim_seen = 0;
    drv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(2);
      drv_seen += int'(DRV_UP | DRV_DN);
    end
    check_val("bottom_no_drive", 32'(drv_seen), 32'(0));
    check_val("bottom_no_limit", 32'(lim_seen), 32'(0));

    // Random command bursts
    done = 0;
    while (done < 3000) begin
      cmd  = $urandom_range(0, 9);
      cmd  = (cmd < 4) ? 1 : (cmd < 7) ? 2 : (cmd < 8) ? 3 : 0;
      hold = $urandom_range(1, 40);
      for (int i = 0; i < hold; i++) cyc(cmd);
      done += hold;
    end

    // Reset in the middle of an up run
    do_reset("rst3");
    for (int i = 0; i < 2600 && m_pos < 2500; i++) cyc(1);
    check_val("mid_run_pos", 32'(POS), 32'(2500));
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) cyc(0);
    for (int i = 0; i < 10; i++) cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
